// File: rtl/dmem_axil_bridge_pkg.sv
// Shared types and codes for the DMEM AXI4-Lite bridge.
// No logic; constants and typedefs only.
// Imported by the top and by the strobe decoder.
package dmem_axil_bridge_pkg;

  // Bridge FSM states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_WAIT_W  = 3'd1,
    ST_WR_WAIT_AW = 3'd2,
    ST_WR_EXEC    = 3'd3,
    ST_WR_RESP    = 3'd4,
    ST_RD_EXEC    = 3'd5,
    ST_RD_RESP    = 3'd6
  } state_t;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Data memory access size codes
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Captured write request (AW and W may arrive in either order)
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

endpackage

// File: rtl/dmem_strobe_decode.sv
// Maps an AXI write strobe onto the memory's byte/half/word store interface.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the decoded store is used.
module dmem_strobe_decode
  import dmem_axil_bridge_pkg::*;
(
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [1:0]  byte_size,
  output logic [31:0] lane_addr,
  output logic [31:0] shift_data,
  output logic        store,
  output logic        illegal
);

  logic [1:0] lane;
  logic       unused_lsb;

  // Lane comes from the strobe, so the incoming low address bits are ignored
  assign unused_lsb = ^addr[1:0];
  assign lane_addr  = {addr[31:2], lane};

  // Strobe pattern -> access size, lane and right-justified store data
  always_comb begin
    byte_size  = SIZE_BYTE;
    lane       = 2'd0;
    shift_data = 32'd0;
    store      = 1'b0;
    illegal    = 1'b0;
    case (wstrb)
      4'b0001: begin store = 1'b1; lane = 2'd0; shift_data = {24'd0, wdata[7:0]};   end
      4'b0010: begin store = 1'b1; lane = 2'd1; shift_data = {24'd0, wdata[15:8]};  end
      4'b0100: begin store = 1'b1; lane = 2'd2; shift_data = {24'd0, wdata[23:16]}; end
      4'b1000: begin store = 1'b1; lane = 2'd3; shift_data = {24'd0, wdata[31:24]}; end
      4'b0011: begin store = 1'b1; lane = 2'd0; byte_size = SIZE_HALF; shift_data = {16'd0, wdata[15:0]};  end
      4'b1100: begin store = 1'b1; lane = 2'd2; byte_size = SIZE_HALF; shift_data = {16'd0, wdata[31:16]}; end
      4'b1111: begin store = 1'b1; lane = 2'd0; byte_size = SIZE_WORD; shift_data = wdata; end
      4'b0000: store = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_axil_bridge.sv
// AXI4-Lite slave in front of the 1KB data memory; one memory op at a time, read/write alternate priority.
// Latency: handshake edge -> 1 EXEC cycle -> response valid; response held until accepted.
// Backpressure: readies only in IDLE or the half-captured write states; DMEM_BRIDGE_RANGE_CHECK_EN adds DECERR decode.
module dmem_axil_bridge
  import dmem_axil_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [1:0]  mem_byte_size,
  output logic        mem_sign_ext,
  input  logic [31:0] mem_read_data
);

  state_t      state, state_nxt;
  logic        prio_rd;
  wr_req_t     wr_q;
  logic [31:0] rd_addr_q;
  logic [31:0] rdata_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        awready_c, wready_c, arready_c, grant_rd;

  logic [1:0]  dec_size;
  logic [31:0] dec_addr, dec_data;
  logic        dec_store, dec_illegal;
  logic        wr_in_range, rd_in_range, wr_do_store;
  logic [1:0]  wr_resp, rd_resp;

  dmem_strobe_decode u_strobe_decode (
    .wstrb      (wr_q.strb),
    .addr       (wr_q.addr),
    .wdata      (wr_q.data),
    .byte_size  (dec_size),
    .lane_addr  (dec_addr),
    .shift_data (dec_data),
    .store      (dec_store),
    .illegal    (dec_illegal)
  );

`ifdef DMEM_BRIDGE_RANGE_CHECK_EN
  assign wr_in_range = ((dec_addr - BASE_ADDR) < MEM_BYTES);
  assign rd_in_range = ((rd_addr_q - BASE_ADDR) < MEM_BYTES);
`else
  // Without the range check the address is passed through and the memory aliases
  logic unused_cfg;
  assign unused_cfg  = ^{BASE_ADDR, MEM_BYTES, rd_addr_q[1:0]};
  assign wr_in_range = 1'b1;
  assign rd_in_range = 1'b1;
`endif

  // Out-of-window beats illegal strobes: the address decode is the outer check
  assign wr_do_store = dec_store & wr_in_range;
  assign wr_resp     = !wr_in_range ? RESP_DECERR :
                       (dec_illegal ? RESP_SLVERR : RESP_OKAY);
  assign rd_resp     = rd_in_range ? RESP_OKAY : RESP_DECERR;

  // Read wins in IDLE only when it holds priority or no write channel is asking
  assign grant_rd = s_arvalid & (prio_rd | ~(s_awvalid | s_wvalid));

  // Next-state and channel readies
  always_comb begin
    state_nxt = state;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    arready_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_rd) begin
          arready_c = 1'b1;
          state_nxt = ST_RD_EXEC;
        end else if (s_awvalid | s_wvalid) begin
          awready_c = 1'b1;
          wready_c  = 1'b1;
          if (s_awvalid & s_wvalid) state_nxt = ST_WR_EXEC;
          else if (s_awvalid)       state_nxt = ST_WR_WAIT_W;
          else                      state_nxt = ST_WR_WAIT_AW;
        end
      end
      ST_WR_WAIT_W: begin
        wready_c = 1'b1;
        if (s_wvalid) state_nxt = ST_WR_EXEC;
      end
      ST_WR_WAIT_AW: begin
        awready_c = 1'b1;
        if (s_awvalid) state_nxt = ST_WR_EXEC;
      end
      ST_WR_EXEC: state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (s_bready) state_nxt = ST_IDLE;
      ST_RD_EXEC: state_nxt = ST_RD_RESP;
      ST_RD_RESP: if (s_rready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign s_awready = awready_c & reset_n;
  assign s_wready  = wready_c & reset_n;
  assign s_arready = arready_c & reset_n;

  // State register and read/write priority flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      prio_rd <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_WR_RESP && s_bready)      prio_rd <= 1'b1;
      else if (state == ST_RD_RESP && s_rready) prio_rd <= 1'b0;
    end
  end

  // Request capture on each channel handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q      <= '0;
      rd_addr_q <= 32'd0;
    end else begin
      if (s_awvalid & s_awready) wr_q.addr <= s_awaddr;
      if (s_wvalid & s_wready) begin
        wr_q.data <= s_wdata;
        wr_q.strb <= s_wstrb;
      end
      if (s_arvalid & s_arready) rd_addr_q <= s_araddr;
    end
  end

  // Response registers loaded at the end of the EXEC cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= 32'd0;
    end else begin
      if (state == ST_WR_EXEC) bresp_q <= wr_resp;
      if (state == ST_RD_EXEC) begin
        rresp_q <= rd_resp;
        rdata_q <= rd_in_range ? mem_read_data : 32'd0;
      end
    end
  end

  assign s_bvalid = (state == ST_WR_RESP);
  assign s_rvalid = (state == ST_RD_RESP);
  assign s_bresp  = bresp_q;
  assign s_rresp  = rresp_q;
  assign s_rdata  = rdata_q;

  // Memory port is driven only while an access actually happens
  always_comb begin
    mem_address    = 32'd0;
    mem_write_data = 32'd0;
    mem_memwrite   = 1'b0;
    mem_memread    = 1'b0;
    mem_byte_size  = SIZE_BYTE;
    if (state == ST_WR_EXEC && wr_do_store) begin
      mem_address    = dec_addr;
      mem_write_data = dec_data;
      mem_memwrite   = 1'b1;
      mem_byte_size  = dec_size;
    end else if (state == ST_RD_EXEC && rd_in_range) begin
      mem_address   = {rd_addr_q[31:2], 2'b00};
      mem_memread   = 1'b1;
      mem_byte_size = SIZE_WORD;
    end
  end

  assign mem_sign_ext = 1'b0;

endmodule

// File: tb/tb_dmem_axil_bridge.sv
// Testbench for dmem_axil_bridge: byte-array reference model plus response scoreboard.
// Directed cases for ordering, strobes, stalls and reset, then randomized traffic.
module tb_dmem_axil_bridge;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp, mem_byte_size;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread, mem_sign_ext;

  always #5 clock = ~clock;

  dmem_axil_bridge dut (
    .clock(clock), .reset_n(reset_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_byte_size(mem_byte_size), .mem_sign_ext(mem_sign_ext),
    .mem_read_data(mem_read_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: no handshake within cycle budget", nm);
  endtask

  // ---------------- data memory stand-in ----------------
  logic [7:0] env_mem [0:1023];
  int         st_cnt = 0, rd_cnt = 0;
  logic [31:0] last_st_addr, last_st_data;
  logic [1:0]  last_st_size;

  assign mem_read_data = {env_mem[{mem_address[9:2], 2'd3}], env_mem[{mem_address[9:2], 2'd2}],
                          env_mem[{mem_address[9:2], 2'd1}], env_mem[{mem_address[9:2], 2'd0}]};

  always @(posedge clock) begin
    if (mem_memwrite) begin
      st_cnt++;
      last_st_addr = mem_address;
      last_st_data = mem_write_data;
      last_st_size = mem_byte_size;
      case (mem_byte_size)
        2'b00: env_mem[mem_address[9:0]] <= mem_write_data[7:0];
        2'b01: begin
          env_mem[{mem_address[9:1], 1'b0}] <= mem_write_data[7:0];
          env_mem[{mem_address[9:1], 1'b1}] <= mem_write_data[15:8];
        end
        default: begin
          env_mem[{mem_address[9:2], 2'd0}] <= mem_write_data[7:0];
          env_mem[{mem_address[9:2], 2'd1}] <= mem_write_data[15:8];
          env_mem[{mem_address[9:2], 2'd2}] <= mem_write_data[23:16];
          env_mem[{mem_address[9:2], 2'd3}] <= mem_write_data[31:24];
        end
      endcase
    end
    if (mem_memread) rd_cnt++;
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem [0:1023];
  bit         model_prio_rd = 0;
  int         exp_st_cnt = 0, exp_rd_cnt = 0;

  function automatic bit in_win(input logic [31:0] a);
    bit w;
    w = (a >= 32'h1000_0000) && (a < 32'h1000_0400);
`ifdef DMEM_BRIDGE_RANGE_CHECK_EN
    return w;
`else
    return w | 1'b1;
`endif
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[{a[9:2], 2'b00} + 10'(i)];
    return w;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d);
    exp_t e;
    bit   legal;
    legal = (st == 4'h1) || (st == 4'h2) || (st == 4'h4) || (st == 4'h8) ||
            (st == 4'h3) || (st == 4'hC) || (st == 4'hF);
    e.is_rd = 0;
    e.data  = 32'd0;
    if (!in_win(a))     e.resp = 2'b11;
    else if (st == 4'h0) e.resp = 2'b00;
    else if (!legal)    e.resp = 2'b10;
    else begin
      e.resp = 2'b00;
      for (int i = 0; i < 4; i++)
        if (st[i]) ref_mem[{a[9:2], 2'b00} + 10'(i)] = d[8*i +: 8];
      exp_st_cnt++;
    end
    exp_q.push_back(e);
    model_prio_rd = 1;
  endtask

  task automatic model_read(input logic [31:0] a);
    exp_t e;
    e.is_rd = 1;
    if (in_win(a)) begin
      e.resp = 2'b00;
      e.data = ref_word(a);
      exp_rd_cnt++;
    end else begin
      e.resp = 2'b11;
      e.data = 32'd0;
    end
    exp_q.push_back(e);
    model_prio_rd = 0;
  endtask

  // ---------------- channel drivers ----------------
  task automatic drv_aw(input logic [31:0] a, input int dly);
    bit hs, done;
    done = 0;
    repeat (dly) @(negedge clock);
    s_awaddr = a; s_awvalid = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      #1 hs = s_awready;
      @(posedge clock);
      if (hs) done = 1; else @(negedge clock);
    end
    #1 s_awvalid = 0;
    if (!done) timeout("aw_handshake");
    @(negedge clock);
  endtask

  task automatic drv_w(input logic [31:0] d, input logic [3:0] st, input int dly);
    bit hs, done;
    done = 0;
    repeat (dly) @(negedge clock);
    s_wdata = d; s_wstrb = st; s_wvalid = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      #1 hs = s_wready;
      @(posedge clock);
      if (hs) done = 1; else @(negedge clock);
    end
    #1 s_wvalid = 0;
    if (!done) timeout("w_handshake");
    @(negedge clock);
  endtask

  task automatic drv_ar(input logic [31:0] a, input int dly);
    bit hs, done;
    done = 0;
    repeat (dly) @(negedge clock);
    s_araddr = a; s_arvalid = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      #1 hs = s_arready;
      @(posedge clock);
      if (hs) done = 1; else @(negedge clock);
    end
    #1 s_arvalid = 0;
    if (!done) timeout("ar_handshake");
    @(negedge clock);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) ok = 1;
    end
    if (!ok) timeout("response_drain");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d,
                          input int aw_dly, input int w_dly);
    model_write(a, st, d);
    fork
      drv_aw(a, aw_dly);
      drv_w(d, st, w_dly);
    join
    wait_drain();
  endtask

  task automatic do_read(input logic [31:0] a, input int dly);
    model_read(a);
    drv_ar(a, dly);
    wait_drain();
  endtask

  // Both sides valid in the same IDLE cycle; model priority decides the order
  task automatic do_contend(input logic [31:0] wa, input logic [31:0] d, input logic [31:0] ra);
    if (model_prio_rd) begin
      model_read(ra); model_write(wa, 4'hF, d);
    end else begin
      model_write(wa, 4'hF, d); model_read(ra);
    end
    fork
      drv_aw(wa, 0);
      drv_w(d, 4'hF, 0);
      drv_ar(ra, 0);
    join
    wait_drain();
  endtask

  // ---------------- response readies ----------------
  int hold_b = 0, hold_r = 0;

  initial begin
    s_bready = 0; s_rready = 0;
    forever begin
      @(negedge clock);
      if (hold_b > 0) begin s_bready = 0; hold_b--; end
      else s_bready = ($urandom_range(0, 3) != 0);
      if (hold_r > 0) begin s_rready = 0; hold_r--; end
      else s_rready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  initial begin
    exp_t        e;
    bit          pb, pr;
    logic [1:0]  pbresp, prresp;
    logic [31:0] prdata;
    pb = 0; pr = 0; pbresp = 0; prresp = 0; prdata = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset_n) begin pb = 0; pr = 0; continue; end
      if (pb) begin
        chk("bvalid_held", {31'd0, s_bvalid}, 32'd1);
        chk("bresp_stable", {30'd0, s_bresp}, {30'd0, pbresp});
      end
      if (pr) begin
        chk("rvalid_held", {31'd0, s_rvalid}, 32'd1);
        chk("rdata_stable", s_rdata, prdata);
        chk("rresp_stable", {30'd0, s_rresp}, {30'd0, prresp});
      end
      if (s_bvalid || s_rvalid)
        chk("readies_in_resp", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
      if (s_bvalid && s_bready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_b: bresp=%b while no response expected", s_bresp);
        end else begin
          e = exp_q.pop_front();
          chk("b_order_is_rd", 32'd0, {31'd0, e.is_rd});
          chk("bresp", {30'd0, s_bresp}, {30'd0, e.resp});
        end
      end
      if (s_rvalid && s_rready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_r: rdata=%h while no response expected", s_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("r_order_is_rd", 32'd1, {31'd0, e.is_rd});
          chk("rresp", {30'd0, s_rresp}, {30'd0, e.resp});
          chk("rdata", s_rdata, e.data);
        end
      end
      pb = s_bvalid & ~s_bready; pbresp = s_bresp;
      pr = s_rvalid & ~s_rready; prresp = s_rresp; prdata = s_rdata;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int st0, rd0;
    bit seen;
    logic [31:0] a, d;
    logic [3:0]  st;
    logic [3:0]  legal_strb [0:6];
    legal_strb[0] = 4'h1; legal_strb[1] = 4'h2; legal_strb[2] = 4'h4; legal_strb[3] = 4'h8;
    legal_strb[4] = 4'h3; legal_strb[5] = 4'hC; legal_strb[6] = 4'hF;
    for (int i = 0; i < 1024; i++) begin env_mem[i] = 8'd0; ref_mem[i] = 8'd0; end

    // Reset with requests pending: everything quiet
    reset_n = 0;
    s_awaddr = 32'h1000_0000; s_wdata = 0; s_wstrb = 4'hF; s_araddr = 32'h1000_0000;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
    chk("rst_valids", {30'd0, s_bvalid, s_rvalid}, 32'd0);
    chk("rst_resps", {28'd0, s_bresp, s_rresp}, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    chk("rst_mem_ctrl", {27'd0, mem_memwrite, mem_memread, mem_byte_size, mem_sign_ext}, 32'd0);
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);

    // Contention straight out of reset: write first
    do_contend(32'h1000_0030, 32'h1234_5678, 32'h1000_0030);
    // A lone write hands priority to reads, so the next contention serves the read first
    do_write(32'h1000_0040, 4'h1, 32'h0000_0055, 0, 0);
    do_contend(32'h1000_0030, 32'hCAFE_F00D, 32'h1000_0030);

    // Full word store, AW and W together
    st0 = st_cnt;
    do_write(32'h1000_0010, 4'hF, 32'hDEAD_BEEF, 0, 0);
    chk("sw_store_count", st_cnt - st0, 32'd1);
    chk("sw_address", last_st_addr, 32'h1000_0010);
    chk("sw_size", {30'd0, last_st_size}, 32'd2);
    do_read(32'h1000_0010, 0);

    // Byte store, W before AW
    do_write(32'h1000_0020, 4'b0100, 32'h00AB_0000, 2, 0);
    chk("sb_address", last_st_addr, 32'h1000_0022);
    chk("sb_data", last_st_data, 32'h0000_00AB);
    chk("sb_size", {30'd0, last_st_size}, 32'd0);
    do_read(32'h1000_0020, 1);

    // Illegal and empty strobes never store
    st0 = st_cnt;
    do_write(32'h1000_0024, 4'b0110, 32'hFFFF_FFFF, 0, 1);
    do_write(32'h1000_0028, 4'b0000, 32'hFFFF_FFFF, 1, 0);
    chk("no_store_count", st_cnt - st0, 32'd0);

    // Write response stalled while a read waits
    model_write(32'h1000_0050, 4'hF, 32'hA5A5_0F0F);
    hold_b = 1000;
    fork
      drv_aw(32'h1000_0050, 0);
      drv_w(32'hA5A5_0F0F, 4'hF, 0);
    join
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clock); #2; seen = s_bvalid; end
    if (!seen) timeout("bvalid_appear");
    model_read(32'h1000_0050);
    fork drv_ar(32'h1000_0050, 0); join_none
    repeat (5) begin
      @(negedge clock); #3;
      chk("bstall_bvalid", {31'd0, s_bvalid}, 32'd1);
      chk("bstall_arready", {31'd0, s_arready}, 32'd0);
    end
    hold_b = 0;
    wait_drain();

    // Read response stalled while a write waits
    model_read(32'h1000_0010);
    hold_r = 1000;
    drv_ar(32'h1000_0010, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clock); #2; seen = s_rvalid; end
    if (!seen) timeout("rvalid_appear");
    model_write(32'h1000_0014, 4'hC, 32'h7777_0000);
    fork
      drv_aw(32'h1000_0014, 0);
      drv_w(32'h7777_0000, 4'hC, 0);
    join_none
    repeat (5) begin
      @(negedge clock); #3;
      chk("rstall_rvalid", {31'd0, s_rvalid}, 32'd1);
      chk("rstall_rdata", s_rdata, 32'hDEAD_BEEF);
      chk("rstall_wr_readies", {30'd0, s_awready, s_wready}, 32'd0);
    end
    hold_r = 0;
    wait_drain();

`ifdef DMEM_BRIDGE_RANGE_CHECK_EN
    rd0 = rd_cnt;
    do_read(32'h1000_0400, 0);
    chk("oor_no_memread", rd_cnt - rd0, 32'd0);
    st0 = st_cnt;
    do_write(32'h0FFF_FFFC, 4'hF, 32'h1111_2222, 0, 0);
    chk("oor_no_store", st_cnt - st0, 32'd0);
`else
    rd0 = rd_cnt;
    do_read(32'h1000_0410, 0);
    chk("alias_memread", rd_cnt - rd0, 32'd1);
`endif

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h1000_0000 + $urandom_range(1024, 4095);
        1:       a = 32'h0FFF_FC00 + $urandom_range(0, 1023);
        default: a = 32'h1000_0000 + $urandom_range(0, 1023);
      endcase
      d = $urandom;
      if ($urandom_range(0, 3) == 0) st = 4'($urandom);
      else st = legal_strb[$urandom_range(0, 6)];
      if ($urandom_range(0, 2) == 0) do_read(a, $urandom_range(0, 2));
      else do_write(a, st, d, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while AW is held waiting for W: transaction is dropped
    drv_aw(32'h1000_0060, 0);
    st0 = st_cnt;
    reset_n = 0;
    s_wdata = 32'hBAD0_BAD0; s_wstrb = 4'hF; s_wvalid = 1; s_arvalid = 1;
    #1;
    chk("midrst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
    chk("midrst_bvalid", {31'd0, s_bvalid}, 32'd0);
    chk("midrst_memwrite", {31'd0, mem_memwrite}, 32'd0);
    repeat (2) @(negedge clock);
    s_wvalid = 0; s_arvalid = 0;
    @(negedge clock);
    reset_n = 1;
    model_prio_rd = 0;
    repeat (2) @(negedge clock);
    chk("midrst_no_store", st_cnt - st0, 32'd0);
    do_read(32'h1000_0060, 0);
    do_write(32'h1000_0060, 4'h3, 32'h0000_BEEF, 1, 0);
    do_read(32'h1000_0060, 0);

    repeat (3) @(negedge clock);
    chk("total_stores", st_cnt, exp_st_cnt);
    chk("total_memreads", rd_cnt, exp_rd_cnt);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
